usb_line_receiver: RTL and testbench



---
 rtl/usb_serial_pkg.sv | 33 +++
 rtl/usb_line_buffer.sv | 54 +++++
 rtl/usb_line_receiver.sv | 90 +++++++++
 tb/tb_usb_line_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_serial_pkg.sv
// Shared constants and helpers for the USB serial line path (sender and receiver).
package usb_serial_pkg;

  // Control and printable-range characters
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_DEL   = 8'h7F;
  localparam logic [7:0] CHAR_SP    = 8'h20;
  localparam logic [7:0] CHAR_TILDE = 8'h7E;

  // Receiver state encoding
  localparam logic RX_COLLECT = 1'b0;
  localparam logic RX_HOLD    = 1'b1;

  typedef enum logic {
    ST_COLLECT = RX_COLLECT,
    ST_HOLD    = RX_HOLD
  } rx_state_e;

  function automatic logic is_terminator(input logic [7:0] b);
    return (b == CHAR_CR) || (b == CHAR_LF);
  endfunction

  function automatic logic is_erase(input logic [7:0] b);
    return (b == CHAR_BS) || (b == CHAR_DEL);
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CHAR_SP) && (b <= CHAR_TILDE);
  endfunction

endpackage

// File: rtl/usb_line_buffer.sv
// Line shift register with length counter. Newest character sits in [7:0];
// pop undoes the last push; clear empties the line. Clear has priority.
module usb_line_buffer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             push_byte,
  input  logic                   pop,
  input  logic                   clear,
  output logic [8*MAX_LEN-1:0]   data,
  output logic [LEN_W-1:0]       len,
  output logic                   full,
  output logic                   empty
);

  logic [8*MAX_LEN-1:0] data_q, data_d;
  logic [LEN_W-1:0]     len_q, len_d;

  assign full  = (len_q == LEN_W'(MAX_LEN));
  assign empty = (len_q == '0);
  assign data  = data_q;
  assign len   = len_q;

  // Next-state: push/pop are guarded against full/empty so callers need not care
  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (clear) begin
      data_d = '0;
      len_d  = '0;
    end else if (push && !full) begin
      data_d = {data_q[8*MAX_LEN-9:0], push_byte};
      len_d  = len_q + LEN_W'(1);
    end else if (pop && !empty) begin
      data_d = data_q >> 8;
      len_d  = len_q - LEN_W'(1);
    end
  end

  // Buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      len_q  <= '0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: rtl/usb_line_receiver.sv
// Assembles bytes from usb_uart into lines with backspace editing and hands
// each completed line to a command decoder via valid/ready.
module usb_line_receiver
  import usb_serial_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  input  logic [7:0]            uart_out_data,
  input  logic                  uart_out_valid,
  output logic                  uart_out_ready,
  output logic [8*MAX_LEN-1:0]  line_data,
  output logic [LEN_W-1:0]      line_len,
  output logic                  line_overflow,
  output logic                  line_valid,
  input  logic                  line_ready
);

  rx_state_e state_q, state_d;
  logic      overflow_q, overflow_d;
  logic      buf_push, buf_pop, buf_clear;
  logic      buf_full, buf_empty;

  usb_line_buffer #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_buf (
    .clk       (clk_48mhz),
    .rst_n     (reset_n),
    .push      (buf_push),
    .push_byte (uart_out_data),
    .pop       (buf_pop),
    .clear     (buf_clear),
    .data      (line_data),
    .len       (line_len),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Handshake outputs decode the state register only, so no input-to-output path
  assign uart_out_ready = (state_q == ST_COLLECT);
  assign line_valid     = (state_q == ST_HOLD);
  assign line_overflow  = overflow_q;

  // Next-state and buffer control: classify accepted bytes, release line on ready
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    buf_push   = 1'b0;
    buf_pop    = 1'b0;
    buf_clear  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (uart_out_valid) begin
          if (is_terminator(uart_out_data)) begin
            // Empty lines (including the LF of CRLF) produce nothing
            if (!buf_empty) state_d = ST_HOLD;
          end else if (is_erase(uart_out_data)) begin
            buf_pop = 1'b1;
          end else if (is_printable(uart_out_data)) begin
            if (buf_full) overflow_d = 1'b1;
            else          buf_push   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (line_ready) begin
          buf_clear  = 1'b1;
          overflow_d = 1'b0;
          state_d    = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // State and sticky overflow registers
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_COLLECT;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_usb_line_receiver.sv
// Self-checking bench: behavioural line model (byte queue) compared every cycle,
// plus directed scenarios with literal expectations and a randomized run.
module tb_usb_line_receiver;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic                 clk_48mhz = 1'b0;
  logic                 reset_n   = 1'b0;
  logic [7:0]           uart_out_data  = 8'h00;
  logic                 uart_out_valid = 1'b0;
  logic                 uart_out_ready;
  logic [8*MAX_LEN-1:0] line_data;
  logic [LEN_W-1:0]     line_len;
  logic                 line_overflow;
  logic                 line_valid;
  logic                 line_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // Behavioural model: the line as a queue of characters
  logic [7:0] mq[$];
  logic       m_hold = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       chk_en = 1'b0;
  int         lines_out = 0;

  usb_line_receiver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk_48mhz      (clk_48mhz),
    .reset_n        (reset_n),
    .uart_out_data  (uart_out_data),
    .uart_out_valid (uart_out_valid),
    .uart_out_ready (uart_out_ready),
    .line_data      (line_data),
    .line_len       (line_len),
    .line_overflow  (line_overflow),
    .line_valid     (line_valid),
    .line_ready     (line_ready)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_pack();
    logic [255:0] p = '0;
    foreach (mq[i]) p = (p << 8) | 256'(mq[i]);
    return p;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_hold = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs present at that edge
  task automatic tick();
    logic [7:0] b;
    @(posedge clk_48mhz);
    b = uart_out_data;
    #1;
    if (!reset_n) begin
      model_clear();
    end else if (m_hold) begin
      if (line_ready) begin
        lines_out++;
        model_clear();
      end
    end else if (uart_out_valid) begin
      if (b == 8'h0D || b == 8'h0A) begin
        if (mq.size() > 0) m_hold = 1'b1;
      end else if (b == 8'h08 || b == 8'h7F) begin
        if (mq.size() > 0) void'(mq.pop_back());
      end else if (b >= 8'h20 && b <= 8'h7E) begin
        if (mq.size() < MAX_LEN) mq.push_back(b);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    uart_out_valid = 1'b1;
    uart_out_data  = b;
    line_ready     = 1'b0;
    tick();
    uart_out_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    uart_out_valid = 1'b0;
    line_ready     = rdy;
    for (int i = 0; i < n; i++) tick();
    line_ready = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Compare process: every cycle, DUT against the model
  always @(negedge clk_48mhz) begin
    if (chk_en) begin
      chk("ready",    256'(uart_out_ready), 256'(!m_hold));
      chk("valid",    256'(line_valid),     256'(m_hold));
      chk("len",      256'(line_len),       256'(mq.size()));
      chk("overflow", 256'(line_overflow),  256'(m_ovf));
      chk("data",     line_data,            model_pack());
    end
  end

  initial begin
    logic [7:0] b;
    logic [255:0] snap;
    int r;

    // Reset state
    repeat (3) @(posedge clk_48mhz);
    #3 reset_n = 1'b1;
    #1;
    chk("rst_ready", 256'(uart_out_ready), 256'(1));
    chk("rst_valid", 256'(line_valid), 256'(0));
    chk("rst_len",   256'(line_len), 256'(0));
    chk("rst_data",  line_data, 256'(0));
    chk("rst_ovf",   256'(line_overflow), 256'(0));
    chk_en = 1'b1;

    // 1: "ab\r" held until line_ready
    send_str("ab");
    send(8'h0D);
    chk("t1_valid", 256'(line_valid), 256'(1));
    chk("t1_data",  line_data, 256'h6162);
    chk("t1_len",   256'(line_len), 256'(2));
    chk("t1_ovf",   256'(line_overflow), 256'(0));
    idle(4, 1'b0);
    chk("t1_ready_held", 256'(uart_out_ready), 256'(0));
    idle(1, 1'b1);
    chk("t1_release", 256'(line_valid), 256'(0));
    chk("t1_lines", 256'(lines_out), 256'(1));

    // 2: blank terminators produce nothing
    send(8'h0D); send(8'h0A); send(8'h0D);
    chk("t2_blank", 256'(line_valid), 256'(0));
    send_str("x"); send(8'h0A);
    chk("t2_data", line_data, 256'h78);
    chk("t2_len",  256'(line_len), 256'(1));
    idle(1, 1'b1);
    send(8'h0A);
    chk("t2_trail", 256'(line_valid), 256'(0));
    chk("t2_lines", 256'(lines_out), 256'(2));

    // 3: backspace / delete editing
    send_str("abc"); send(8'h08); send(8'h7F); send(8'h7F); send(8'h7F);
    send_str("z"); send(8'h0D);
    chk("t3_len",  256'(line_len), 256'(1));
    chk("t3_data", line_data, 256'h7A);
    idle(1, 1'b1);

    // 4: overflow
    for (int i = 0; i < 34; i++) send(8'h41 + 8'(i));
    send(8'h0D);
    chk("t4_len",  256'(line_len), 256'(32));
    chk("t4_ovf",  256'(line_overflow), 256'(1));
    chk("t4_low",  256'(line_data[7:0]), 256'h60);
    chk("t4_high", 256'(line_data[255:248]), 256'h41);
    idle(1, 1'b1);
    send_str("k"); send(8'h0D);
    chk("t4_next_ovf", 256'(line_overflow), 256'(0));
    idle(1, 1'b1);

    // 5: backpressure in HOLD
    send_str("m"); send(8'h0D);
    snap = line_data;
    uart_out_valid = 1'b1; uart_out_data = 8'h71; line_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_frozen", line_data, snap);
    chk("t5_len",    256'(line_len), 256'(1));
    line_ready = 1'b1; tick();
    line_ready = 1'b0; tick();
    uart_out_valid = 1'b0;
    chk("t5_q_taken", line_data, 256'h71);
    send(8'h0D);
    chk("t5_line", 256'(line_valid), 256'(1));
    idle(1, 1'b1);

    // 6: asynchronous reset mid-line
    send_str("ab");
    @(negedge clk_48mhz);
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    chk("t6_rst_valid", 256'(line_valid), 256'(0));
    chk("t6_rst_len",   256'(line_len), 256'(0));
    @(posedge clk_48mhz);
    #3 reset_n = 1'b1;
    chk("t6_after_valid", 256'(line_valid), 256'(0));
    send_str("c"); send(8'h0D);
    chk("t6_len",  256'(line_len), 256'(1));
    chk("t6_data", line_data, 256'h63);
    idle(1, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      b = 8'(32 + $urandom_range(0, 94));
      else if (r < 78) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
      else if (r < 90) b = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
      else             b = 8'($urandom_range(0, 255));
      uart_out_data  = b;
      uart_out_valid = ($urandom_range(0, 3) != 0);
      line_ready     = ($urandom_range(0, 2) == 0);
      tick();
    end
    uart_out_valid = 1'b0;
    line_ready     = 1'b0;
    @(negedge clk_48mhz);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
